// File: rtl/ps2_dual_packet_arbiter.sv
// ps2_dual_packet_arbiter
// Frames two independent PS/2 mouse byte streams into 3-byte packets. Each
// port has its own framer and a one-entry holding buffer. The buffered packets
// are round-robin arbitrated onto one valid/ready packet output.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   byte_valid0/byte0        port 0 byte strobe and byte
//   byte_valid1/byte1        port 1 byte strobe and byte
//   pkt_valid/pkt_ready      output handshake
//   pkt_data[23:0]           {first, second, third} byte; first byte in [23:16]
//   pkt_src                  source port of pkt_data
//   drop_cnt0/drop_cnt1      saturating count of packets lost to a full buffer
//   timeout_cnt              saturating count of abandoned partial packets
module ps2_dual_packet_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        byte_valid0,
   input  logic [7:0]  byte0,
   input  logic        byte_valid1,
   input  logic [7:0]  byte1,
   output logic        pkt_valid,
   input  logic        pkt_ready,
   output logic [23:0] pkt_data,
   output logic        pkt_src,
   output logic [7:0]  drop_cnt0,
   output logic [7:0]  drop_cnt1,
   output logic [7:0]  timeout_cnt
);

   localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,
      ST_B2   = 2'd1,
      ST_B3   = 2'd2
   } frame_state_t;

   logic [1:0]  byte_valid_w;
   logic [7:0]  byte_w [2];

   logic [1:0]  pkt_done_w;
   logic [23:0] pkt_word_w [2];
   logic [1:0]  timed_out_w;
   logic [1:0]  buf_full_w;
   logic [23:0] buf_data_w [2];
   logic [7:0]  drop_cnt_w [2];

   logic        load;
   logic        grant;
   logic        both_full;

   logic        pkt_valid_reg;
   logic [23:0] pkt_data_reg;
   logic        pkt_src_reg;
   logic        last_grant_reg;
   logic [7:0]  timeout_cnt_reg;
   logic [9:0]  timeout_sum;

   assign byte_valid_w = {byte_valid1, byte_valid0};
   assign byte_w[0]    = byte0;
   assign byte_w[1]    = byte1;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         frame_state_t state_reg, state_next;
         logic [7:0]   idle_reg, idle_next;
         logic [7:0]   b1_reg, b1_next;
         logic [7:0]   b2_reg, b2_next;
         logic         done_c;
         logic         timeout_c;

         logic         full_reg;
         logic [23:0]  data_reg;
         logic [7:0]   drop_reg;
         logic         take;
         logic         write;

         // ---------------- framer ----------------
         always_ff @(posedge clk) begin
            if (reset) begin
               state_reg <= ST_SYNC;
               idle_reg  <= 8'd0;
               b1_reg    <= 8'd0;
               b2_reg    <= 8'd0;
            end else begin
               state_reg <= state_next;
               idle_reg  <= idle_next;
               b1_reg    <= b1_next;
               b2_reg    <= b2_next;
            end
         end

         always_comb begin
            state_next = state_reg;
            idle_next  = idle_reg;
            b1_next    = b1_reg;
            b2_next    = b2_reg;
            done_c     = 1'b0;
            timeout_c  = 1'b0;
            if (state_reg != ST_SYNC && idle_reg == TIMEOUT_L) begin
               // Abandon the partial packet; a byte on this cycle is treated
               // as if the framer were already in SYNC.
               timeout_c  = 1'b1;
               state_next = ST_SYNC;
               idle_next  = 8'd0;
               if (byte_valid_w[gi] && byte_w[gi][3]) begin
                  b1_next    = byte_w[gi];
                  state_next = ST_B2;
               end
            end else begin
               case (state_reg)
                  ST_SYNC: begin
                     idle_next = 8'd0;
                     if (byte_valid_w[gi] && byte_w[gi][3]) begin
                        b1_next    = byte_w[gi];
                        state_next = ST_B2;
                     end
                  end
                  ST_B2: begin
                     if (byte_valid_w[gi]) begin
                        b2_next    = byte_w[gi];
                        idle_next  = 8'd0;
                        state_next = ST_B3;
                     end else begin
                        idle_next = idle_reg + 8'd1;
                     end
                  end
                  ST_B3: begin
                     if (byte_valid_w[gi]) begin
                        done_c     = 1'b1;
                        idle_next  = 8'd0;
                        state_next = ST_SYNC;
                     end else begin
                        idle_next = idle_reg + 8'd1;
                     end
                  end
                  default: begin
                     state_next = ST_SYNC;
                     idle_next  = 8'd0;
                  end
               endcase
            end
         end

         // Third byte comes straight from the input so the packet reaches
         // the buffer on the same edge it is sampled.
         assign pkt_word_w[gi]  = {b1_reg, b2_reg, byte_w[gi]};
         assign pkt_done_w[gi]  = done_c;
         assign timed_out_w[gi] = timeout_c;

         // ---------------- holding buffer ----------------
         assign take  = load && (grant == 1'(gi));
         assign write = done_c && (!full_reg || take);

         always_ff @(posedge clk) begin
            if (reset) begin
               full_reg <= 1'b0;
               data_reg <= 24'd0;
               drop_reg <= 8'd0;
            end else begin
               full_reg <= write || (full_reg && !take);
               if (write) begin
                  data_reg <= pkt_word_w[gi];
               end
               if (done_c && !write && drop_reg != 8'hFF) begin
                  drop_reg <= drop_reg + 8'd1;
               end
            end
         end

         assign buf_full_w[gi] = full_reg;
         assign buf_data_w[gi] = data_reg;
         assign drop_cnt_w[gi] = drop_reg;
      end
   endgenerate

   // ---------------- arbiter / output register ----------------
   assign both_full = &buf_full_w;
   assign load      = (!pkt_valid_reg || pkt_ready) && (|buf_full_w);
   // With a single full buffer, buf_full_w[1] names that port directly.
   assign grant     = both_full ? ~last_grant_reg : buf_full_w[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_valid_reg  <= 1'b0;
         pkt_data_reg   <= 24'd0;
         pkt_src_reg    <= 1'b0;
         last_grant_reg <= 1'b1;  // so port 0 is preferred first
      end else begin
         if (load) begin
            pkt_valid_reg <= 1'b1;
            pkt_data_reg  <= buf_data_w[grant];
            pkt_src_reg   <= grant;
            // The pointer only moves when there was a real choice to make;
            // an uncontested grant leaves the rotation where it was.
            if (both_full) begin
               last_grant_reg <= grant;
            end
         end else if (pkt_ready) begin
            pkt_valid_reg <= 1'b0;
         end
      end
   end

   // Both ports may time out on the same cycle, so add up to 2 and saturate.
   assign timeout_sum = {2'b00, timeout_cnt_reg} + {9'd0, timed_out_w[0]}
                      + {9'd0, timed_out_w[1]};

   always_ff @(posedge clk) begin
      if (reset) begin
         timeout_cnt_reg <= 8'd0;
      end else begin
         timeout_cnt_reg <= (timeout_sum > 10'd255) ? 8'hFF : timeout_sum[7:0];
      end
   end

   assign pkt_valid   = pkt_valid_reg;
   assign pkt_data    = pkt_data_reg;
   assign pkt_src     = pkt_src_reg;
   assign drop_cnt0   = drop_cnt_w[0];
   assign drop_cnt1   = drop_cnt_w[1];
   assign timeout_cnt = timeout_cnt_reg;

endmodule
